// File: rtl/csr_file.sv
// CSR storage with masked read-modify-write over a valid/ready request/response handshake.
// It also owns the hardware-updated mcycle counter and MIP.MTIP, and exports live CSR copies.
module csr_file #(
  parameter logic [63:0] HARTID       = 64'd0,
  parameter logic [4:0]  IDX_MIP      = 5'd2,
  parameter logic [4:0]  IDX_MHARTID  = 5'd4,
  parameter logic [4:0]  IDX_MCYCLE   = 5'd9,
  parameter logic [4:0]  IDX_MTIMECMP = 5'd23,
  parameter logic [4:0]  IDX_INVALID  = 5'd31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_idx,
  input  logic [63:0] req_mask,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_illegal,
  output logic [63:0] csr_mstatus,
  output logic [63:0] csr_mtvec,
  output logic [63:0] csr_satp,
  output logic        mtip
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [63:0] r_regs [0:31];
  logic [1:0]  r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [63:0] r_rsp_rdata;
  logic        r_rsp_illegal;
  logic [1:0]  r_op;
  logic [4:0]  r_idx;
  logic [63:0] r_mask;
  logic [63:0] r_wdata;

  logic [63:0] w_old;
  logic [63:0] w_operand;
  logic [63:0] w_merged;
  logic [63:0] w_new;
  logic        w_write_op;
  logic        w_illegal;
  logic        w_do_write;
  logic        w_mtip_next;

  assign w_mtip_next = (r_regs[IDX_MCYCLE] >= r_regs[IDX_MTIMECMP]);

  // Old value, operand, merged result and legality of the latched request
  always_comb begin
    w_old      = 64'd0;
    w_operand  = 64'd0;
    w_write_op = 1'b0;
    if (r_idx == IDX_MHARTID) begin
      w_old = HARTID;
    end else begin
      w_old = r_regs[r_idx];
    end
    case (r_op)
      OP_READ: begin
        w_operand  = w_old;
        w_write_op = 1'b0;
      end
      OP_WRITE: begin
        w_operand  = r_wdata;
        w_write_op = 1'b1;
      end
      OP_SET: begin
        w_operand  = w_old | r_wdata;
        w_write_op = (r_wdata != 64'd0);
      end
      OP_CLEAR: begin
        w_operand  = w_old & ~r_wdata;
        w_write_op = (r_wdata != 64'd0);
      end
      default: begin
        w_operand  = w_old;
        w_write_op = 1'b0;
      end
    endcase
    w_illegal  = (r_idx == IDX_INVALID) || (w_write_op && (r_idx == IDX_MHARTID));
    w_do_write = w_write_op && !w_illegal;
    w_merged   = (w_old & ~r_mask) | (w_operand & r_mask);
    // MTIP is hardware-owned: a software write never lands on bit 7
    w_new      = (r_idx == IDX_MIP) ? {w_merged[63:8], w_mtip_next, w_merged[6:0]} : w_merged;
  end

  // CSR storage: mcycle/MTIP hardware updates, overridden by a committed write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 64'd0;
      end
    end else begin
      r_regs[IDX_MCYCLE]  <= r_regs[IDX_MCYCLE] + 64'd1;
      r_regs[IDX_MIP][7]  <= w_mtip_next;
      if ((r_state == ST_EXEC) && w_do_write) begin
        r_regs[r_idx] <= w_new;
      end
    end
  end

  // Request/response FSM: IDLE accepts, EXEC commits and loads the response, RESP holds it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 64'd0;
      r_rsp_illegal <= 1'b0;
      r_op          <= 2'd0;
      r_idx         <= 5'd0;
      r_mask        <= 64'd0;
      r_wdata       <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_idx       <= req_idx;
            r_mask      <= req_mask;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_rdata   <= w_illegal ? 64'd0 : (w_old & r_mask);
          r_rsp_illegal <= w_illegal;
          r_rsp_valid   <= 1'b1;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_illegal = r_rsp_illegal;
  assign csr_mstatus = r_regs[0];
  assign csr_mtvec   = r_regs[3];
  assign csr_satp    = r_regs[7];
  assign mtip        = r_regs[IDX_MIP][7];

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: table-driven vectors with a response scoreboard,
// plus hand-written sequences for live outputs, MTIP timing, mcycle wrap, RESP hold and reset.
module tb_csr_file;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]  OPR  = 2'b00;
  localparam logic [1:0]  OPW  = 2'b01;
  localparam logic [1:0]  OPS  = 2'b10;
  localparam logic [1:0]  OPC  = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_idx;
  logic [63:0] req_mask;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_illegal;
  logic [63:0] csr_mstatus;
  logic [63:0] csr_mtvec;
  logic [63:0] csr_satp;
  logic        mtip;

  typedef struct {
    logic [63:0] rdata;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ill;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[19];
  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  int          e_base = 0;
  logic [63:0] m_base = 64'd0;

  csr_file #(.HARTID(64'd3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_idx(req_idx),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .csr_mstatus(csr_mstatus), .csr_mtvec(csr_mtvec), .csr_satp(csr_satp), .mtip(mtip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [63:0] mcyc_at(input int n);
    return m_base + 64'(n - e_base);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every completed response against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata %h with no expectation queued", rsp_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.ill});
      end
    end
  end

  // Returns at the falling edge right after acceptance (DUT is then in EXEC).
  // mode 1: expected read data is the modelled mcycle value during EXEC.
  task automatic send(input logic [1:0] op, input logic [4:0] idx, input logic [63:0] mask,
                      input logic [63:0] wdata, input logic [63:0] exp_rdata, input logic exp_ill,
                      input int mode, input bit push);
    int   acc;
    bit   ok;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_idx   = idx;
    req_mask  = mask;
    req_wdata = wdata;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept: got req_ready 0 for 50 cycles expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc = edges;
    e.rdata = (mode == 1) ? (mcyc_at(acc) & mask) : exp_rdata;
    e.ill   = exp_ill;
    if (idx == 5'd9 && op == OPW) begin
      m_base = wdata;
      e_base = acc + 1;
    end
    if (push) q.push_back(e);
  endtask

  initial begin
    int   bad;
    bit   saw0, saw1;
    logic [63:0] held;
    logic [63:0] mexp;

    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_idx = 5'd0;
    req_mask = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b1;

    vecs[0]  = '{OPR, 5'd3,  ONES, 64'd0,          64'd0,          1'b0};
    vecs[1]  = '{OPW, 5'd3,  ONES, 64'h8000_0100,  64'd0,          1'b0};
    vecs[2]  = '{OPR, 5'd3,  ONES, 64'd0,          64'h8000_0100,  1'b0};
    vecs[3]  = '{OPW, 5'd0,  64'h000C_0122, ONES,  64'd0,          1'b0};
    vecs[4]  = '{OPR, 5'd0,  64'h2, 64'd0,         64'h2,          1'b0};
    vecs[5]  = '{OPW, 5'd17, ONES, 64'hF0,         64'd0,          1'b0};
    vecs[6]  = '{OPS, 5'd17, ONES, 64'h0F,         64'hF0,         1'b0};
    vecs[7]  = '{OPC, 5'd17, ONES, 64'hF0,         64'hFF,         1'b0};
    vecs[8]  = '{OPS, 5'd17, ONES, 64'd0,          64'h0F,         1'b0};
    vecs[9]  = '{OPR, 5'd17, ONES, 64'd0,          64'h0F,         1'b0};
    vecs[10] = '{OPW, 5'd4,  ONES, ONES,           64'd0,          1'b1};
    vecs[11] = '{OPS, 5'd4,  ONES, 64'd0,          64'd3,          1'b0};
    vecs[12] = '{OPR, 5'd31, ONES, 64'd0,          64'd0,          1'b1};
    vecs[13] = '{OPR, 5'd4,  ONES, 64'd0,          64'd3,          1'b0};
    vecs[14] = '{OPR, 5'd4,  64'h2, 64'd0,         64'd2,          1'b0};
    vecs[15] = '{OPW, 5'd0,  64'd0, ONES,          64'd0,          1'b0};
    vecs[16] = '{OPC, 5'd0,  ONES, 64'h2,          64'h000C_0122,  1'b0};
    vecs[17] = '{OPR, 5'd0,  ONES, 64'd0,          64'h000C_0120,  1'b0};
    vecs[18] = '{OPW, 5'd31, ONES, ONES,           64'd0,          1'b1};

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
    chk("rst_mtvec", csr_mtvec, 64'd0);
    reset_n = 1'b1;
    m_base = 64'd0;
    e_base = edges;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("mtip_after_reset", {63'd0, mtip}, 64'd1);

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].idx, vecs[i].mask, vecs[i].wdata, vecs[i].rdata, vecs[i].ill, 0, 1'b1);
    end
    repeat (3) @(negedge clk);
    chk("live_mstatus", csr_mstatus, 64'h000C_0120);
    chk("live_mtvec", csr_mtvec, 64'h8000_0100);

    // Live output changes exactly one cycle after the commit
    send(OPW, 5'd3, ONES, 64'h1234_0000, 64'h8000_0100, 1'b0, 0, 1'b1);
    chk("mtvec_in_exec", csr_mtvec, 64'h8000_0100);
    @(negedge clk);
    chk("mtvec_after_commit", csr_mtvec, 64'h1234_0000);
    send(OPW, 5'd7, ONES, 64'h8000_0000_0000_1234, 64'd0, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("live_satp", csr_satp, 64'h8000_0000_0000_1234);

    // MTIP tracks mcycle >= mtimecmp with one register stage
    send(OPW, 5'd9, ONES, 64'd0, 64'd0, 1'b0, 1, 1'b1);
    send(OPW, 5'd23, ONES, 64'd100, 64'd0, 1'b0, 0, 1'b1);
    @(negedge clk);
    bad = 0; saw0 = 1'b0; saw1 = 1'b0;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      if (mtip !== (mcyc_at(edges - 1) >= 64'd100)) bad++;
      if (mtip === 1'b0) saw0 = 1'b1;
      if (mtip === 1'b1) saw1 = 1'b1;
    end
    chk("mtip_track_bad_cycles", 64'(bad), 64'd0);
    chk("mtip_saw_low", {63'd0, saw0}, 64'd1);
    chk("mtip_saw_high", {63'd0, saw1}, 64'd1);

    send(OPW, 5'd23, ONES, ONES, 64'd100, 1'b0, 0, 1'b1);
    send(OPW, 5'd2, ONES, ONES, 64'd0, 1'b0, 0, 1'b1);
    send(OPR, 5'd2, ONES, 64'd0, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("mtip_low_after_mip_write", {63'd0, mtip}, 64'd0);

    // mcycle wraps through 2^64-1; response carries the pre-write value
    send(OPW, 5'd9, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 1, 1'b1);
    send(OPR, 5'd9, ONES, 64'd0, 64'd0, 1'b0, 1, 1'b1);
    mexp = mcyc_at(edges);
    chk("mcycle_wrapped_small", {63'd0, (mexp < 64'd16)}, 64'd1);

    // Response held while the consumer stalls
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    send(OPR, 5'd17, ONES, 64'd0, 64'h0F, 1'b0, 0, 1'b1);
    @(negedge clk);
    held = rsp_rdata;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held) bad++;
      @(negedge clk);
    end
    chk("resp_hold_bad_cycles", 64'(bad), 64'd0);
    chk("resp_hold_value", held, 64'h0F);
    @(posedge clk);
    #1 rsp_ready = 1'b1;

    // Reset while a write to idx 5 sits in EXEC: dropped, never committed
    send(OPW, 5'd5, ONES, 64'hDEAD_BEEF, 64'd0, 1'b0, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_base = 64'd0;
    e_base = edges;
    @(negedge clk);
    chk("rst_exec_req_ready", {63'd0, req_ready}, 64'd1);
    send(OPR, 5'd5, ONES, 64'd0, 64'd0, 1'b0, 0, 1'b1);
    send(OPR, 5'd3, ONES, 64'd0, 64'd0, 1'b0, 0, 1'b1);
    send(OPR, 5'd9, ONES, 64'd0, 64'd0, 1'b0, 1, 1'b1);

    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Storage and access end of the CSR path. Consumes the mapped 5-bit CSR index and the 64-bit write/read mask produced by the CSR address mapper.
- Performs masked read-modify-write for CSRRW/CSRRS/CSRRC (and their immediate forms) issued by the execute stage, over a valid/ready request and response handshake.
- Owns the hardware-updated state: the free-running mcycle counter and the timer-pending bit MIP.MTIP.
- Exports live copies of mstatus, mtvec, satp and MTIP to the trap and MMU logic.

Parameters:
HARTID, 0, value returned for mhartid (index 4); read-only.
IDX_MIP, 2, mapped index of mip.
IDX_MHARTID, 4, mapped index of mhartid.
IDX_MCYCLE, 9, mapped index of mcycle.
IDX_MTIMECMP, 23, mapped index of mtimecmp.
IDX_INVALID, 31, mapped index meaning "no such CSR".

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  2  00 read-only, 01 write, 10 set, 11 clear
req_idx  input  5  mapped CSR index
req_mask  input  64  access mask from the mapper
req_wdata  input  64  operand (rs1 or zero-extended uimm)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_rdata  output  64  old CSR value, masked
rsp_illegal  output  1  access illegal; no state change
csr_mstatus  output  64  live mstatus (index 0)
csr_mtvec  output  64  live mtvec (index 3)
csr_satp  output  64  live satp (index 7)
mtip  output  1  live MIP bit 7

Behaviour:
- Storage: 32 x 64-bit entries.
  - Index 31 is unbacked.
  - Index 4 is unbacked and reads HARTID.
  - All other indices are plain registers.
- FSM states: IDLE, EXEC, RESP. Only one request is outstanding at a time.
  - IDLE: req_ready=1. On req_valid && req_ready, latch op/idx/mask/wdata and go to EXEC.
  - EXEC: req_ready=0. Read old = reg[idx] and compute the result. Commit the write and load rsp_rdata/rsp_illegal at the clock edge ending EXEC. Go to RESP.
  - RESP: rsp_valid=1, req_ready=0. Hold rsp_rdata and rsp_illegal stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE.
  - A request accepted in cycle N gives rsp_valid in cycle N+2 at the earliest. Back-to-back throughput is one request per 3 cycles when rsp_ready is held high.
- Arithmetic:
  - Operand: W = wdata; S = old | wdata; C = old & ~wdata.
  - New value: new = (old & ~mask) | (operand & mask).
  - rsp_rdata = old & mask. Index 0 accessed with the sstatus mask therefore reads and writes only the sstatus view.
- Write suppression: op 00, or op S/C with wdata == 0, performs no write. The response is still returned.
- Illegal access: idx == 31, or any write-performing op to idx 4, gives rsp_illegal=1, rsp_rdata=0 and no state change. A read of idx 4 returns HARTID & mask with rsp_illegal=0.
- mcycle:
  - Increments by 1 every cycle and wraps from 2^64-1 to 0.
  - In the EXEC cycle that writes mcycle, the written value is loaded and the increment is skipped that cycle.
  - The response carries the pre-write value.
- MTIP (mip bit 7):
  - Updated every cycle as (mcycle >= mtimecmp), unsigned, using register values at the start of the cycle.
  - Software writes never change bit 7; bit 7 of the write is forced to the hardware value regardless of the mask.
  - Reads of mip return the current bit 7.
- Live outputs reflect register contents and update the cycle after a committed write.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; all registers are cleared to 0, including mcycle and mtimecmp.
  - rsp_valid=0, rsp_rdata=0, rsp_illegal=0, req_ready=1 after release.
  - A request in EXEC during reset is dropped and never committed.
- req_* inputs are ignored outside IDLE.

Test Plan:
- After reset, read idx 3 with an all-ones mask -> rsp_rdata=0, rsp_illegal=0. Write idx 3 = 0x8000_0100, then read -> 0x8000_0100; csr_mtvec=0x8000_0100 the cycle after the commit.
- idx 0 = 0; op W with wdata=all-ones and mask=0x0000_0000_000C_0122 -> csr_mstatus=0x0000_0000_000C_0122. Read back with mask 0x2 -> rsp_rdata=0x2.
- idx 17 = 0xF0; op S wdata=0x0F -> resp 0xF0, reg 0xFF. Op C wdata=0xF0 -> resp 0xFF, reg 0x0F. Op S wdata=0 -> resp 0x0F, no write.
- mtimecmp=100 with mcycle counting from 0 -> mtip=0 while mcycle<100, 1 from the cycle mcycle reaches 100. Write mip = all-ones -> bit 7 is unchanged and the other masked bits are written.
- Write idx 4 -> rsp_illegal=1, rsp_rdata=0. Access idx 31 -> rsp_illegal=1. Read idx 4 with HARTID=3 -> rsp_rdata=3.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable and req_ready=0. Assert reset_n=0 during EXEC of a write to idx 5 -> rsp_valid=0 immediately and idx 5 reads 0 after reset.
